rggen_register_atomic: RTL and testbench

RGGEN_REGISTER_ATOMIC -- requirements
Module: rggen_register_atomic

---
 rtl/rggen_register_atomic_pkg.sv | 16 +
 rtl/rggen_register_atomic_sub.sv | 45 ++++
 rtl/rggen_register_atomic.sv | 182 ++++++++++++++++++
 tb/tb_rggen_register_atomic.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_register_atomic_pkg.sv
// Shared constants for the rggen register blocks: access encodings, status
// codes and the ready wait counter width.
package rggen_register_atomic_pkg;
    typedef enum logic [1:0] {
        RGGEN_POSTED_WRITE = 2'b01,
        RGGEN_READ         = 2'b10,
        RGGEN_WRITE        = 2'b11
    } rggen_access_e;

    typedef enum logic [1:0] {
        RGGEN_OKAY = 2'b00
    } rggen_status_e;

    localparam int RGGEN_ACCESS_DATA_BIT    = 0;
    localparam int RGGEN_WAIT_COUNTER_WIDTH = 4;
endpackage

// File: rtl/rggen_register_atomic_sub.sv
// Building blocks for rggen registers: a per-word address decoder and a
// one-hot select OR mux.
module rggen_address_decoder #(
    parameter bit READABLE      = 1'b1,
    parameter bit WRITABLE      = 1'b1,
    parameter int WIDTH         = 8,
    parameter int START_ADDRESS = 0,
    parameter int BYTE_SIZE     = 4
) (
    input  logic [WIDTH-1:0] i_address,
    input  logic             i_write,
    input  logic             i_additional_match,
    output logic             o_match
);
    localparam logic [WIDTH-1:0] START = WIDTH'(START_ADDRESS);
    localparam logic [WIDTH-1:0] SIZE  = WIDTH'(BYTE_SIZE);

    logic [WIDTH-1:0] offset;
    logic             access_ok;

    // Offset compare wraps below START, so one unsigned test covers the range.
    always_comb begin
        offset    = i_address - START;
        access_ok = i_write ? WRITABLE : READABLE;
        o_match   = (offset < SIZE) && access_ok && i_additional_match;
    end
endmodule

module rggen_mux #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 2
) (
    input  logic [ENTRIES-1:0]       i_select,
    input  logic [ENTRIES*WIDTH-1:0] i_data,
    output logic [WIDTH-1:0]         o_data
);
    always_comb begin
        o_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (i_select[i]) begin
                o_data = o_data | i_data[i*WIDTH+:WIDTH];
            end
        end
    end
endmodule

// File: rtl/rggen_register_atomic.sv
// Multi-word register with atomic read (word-0 snapshot) and atomic write
// (lower words staged until the last word commits).
module rggen_register_atomic
    import rggen_register_atomic_pkg::*;
#(
    parameter bit READABLE       = 1'b1,
    parameter bit WRITABLE       = 1'b1,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int OFFSET_ADDRESS = 0,
    parameter int BUS_WIDTH      = 32,
    parameter int DATA_WIDTH     = BUS_WIDTH,
    parameter int REGISTER_INDEX = 0,
    parameter bit ATOMIC_READ    = 1'b1,
    parameter bit ATOMIC_WRITE   = 1'b1,
    parameter int READY_LATENCY  = 0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_register_valid,
    input  logic [1:0]               i_register_access,
    input  logic [ADDRESS_WIDTH-1:0] i_register_address,
    input  logic [BUS_WIDTH-1:0]     i_register_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_register_strobe,
    output logic                     o_register_active,
    output logic                     o_register_ready,
    output logic [1:0]               o_register_status,
    output logic [BUS_WIDTH-1:0]     o_register_read_data,
    output logic [DATA_WIDTH-1:0]    o_register_value,
    input  logic                     i_additional_match,
    output logic                     o_bit_field_valid,
    output logic [DATA_WIDTH-1:0]    o_bit_field_read_mask,
    output logic [DATA_WIDTH-1:0]    o_bit_field_write_mask,
    output logic [DATA_WIDTH-1:0]    o_bit_field_write_data,
    input  logic [DATA_WIDTH-1:0]    i_bit_field_read_data,
    input  logic [DATA_WIDTH-1:0]    i_bit_field_value
);
    localparam int WORDS          = DATA_WIDTH / BUS_WIDTH;
    localparam int BYTES_PER_WORD = BUS_WIDTH / 8;
    localparam int DATA_BYTES     = DATA_WIDTH / 8;
    localparam bit ATOMIC_RD      = ATOMIC_READ && (WORDS > 1);
    localparam bit ATOMIC_WR      = ATOMIC_WRITE && (WORDS > 1);
    localparam int CW             = RGGEN_WAIT_COUNTER_WIDTH;
    localparam logic [CW-1:0] LATENCY = CW'(READY_LATENCY);

    logic                   write;
    logic                   access_unused;
    logic [WORDS-1:0]       match;
    logic                   active, ready, bf_valid, staged, commit, word0_read;
    logic [CW-1:0]          count_q, count_d;
    logic [DATA_WIDTH-1:0]  shadow_q, shadow_d;
    logic                   shadow_valid_q, shadow_valid_d;
    logic [DATA_WIDTH-1:0]  stage_data_q, stage_data_d;
    logic [DATA_BYTES-1:0]  stage_mask_q, stage_mask_d;
    logic [DATA_BYTES-1:0]  access_strobe;
    logic [DATA_WIDTH-1:0]  strobe_bits, stage_mask_bits, bus_data_rep;
    logic [DATA_WIDTH-1:0]  word_read_data;

    assign write         = i_register_access[RGGEN_ACCESS_DATA_BIT];
    assign access_unused = i_register_access[1];

    for (genvar k = 0; k < WORDS; k++) begin : g_decoder
        rggen_address_decoder #(
            .READABLE      (READABLE),
            .WRITABLE      (WRITABLE),
            .WIDTH         (ADDRESS_WIDTH),
            .START_ADDRESS (OFFSET_ADDRESS + DATA_BYTES * REGISTER_INDEX + BYTES_PER_WORD * k),
            .BYTE_SIZE     (BYTES_PER_WORD)
        ) u_decoder (
            .i_address          (i_register_address),
            .i_write            (write),
            .i_additional_match (i_additional_match),
            .o_match            (match[k])
        );
    end

    rggen_mux #(
        .WIDTH   (BUS_WIDTH),
        .ENTRIES (WORDS)
    ) u_read_mux (
        .i_select (match),
        .i_data   (word_read_data),
        .o_data   (o_register_read_data)
    );

    always_comb begin
        active     = |match;
        ready      = i_register_valid && active && (count_q == LATENCY);
        count_d    = (i_register_valid && active && !ready) ? count_q + 1'b1 : '0;
        staged     = ATOMIC_WR && write && !match[WORDS-1];
        commit     = ATOMIC_WR && write && match[WORDS-1];
        bf_valid   = ready && !staged;
        word0_read = ATOMIC_RD && !write && match[0];

        access_strobe   = '0;
        bus_data_rep    = '0;
        strobe_bits     = '0;
        stage_mask_bits = '0;
        word_read_data  = '0;
        for (int w = 0; w < WORDS; w++) begin
            bus_data_rep[w*BUS_WIDTH+:BUS_WIDTH] = i_register_write_data;
            if (match[w]) begin
                access_strobe[w*BYTES_PER_WORD+:BYTES_PER_WORD] = i_register_strobe;
            end
            // Upper words come from the word-0 snapshot once one exists.
            if (ATOMIC_RD && (w > 0) && shadow_valid_q) begin
                word_read_data[w*BUS_WIDTH+:BUS_WIDTH] = shadow_q[w*BUS_WIDTH+:BUS_WIDTH];
            end else begin
                word_read_data[w*BUS_WIDTH+:BUS_WIDTH] = i_bit_field_read_data[w*BUS_WIDTH+:BUS_WIDTH];
            end
        end
        for (int b = 0; b < DATA_BYTES; b++) begin
            strobe_bits[b*8+:8]     = {8{access_strobe[b]}};
            stage_mask_bits[b*8+:8] = {8{stage_mask_q[b]}};
        end
    end

    always_comb begin
        o_register_active      = active;
        o_register_ready       = ready;
        o_register_status      = RGGEN_OKAY;
        o_register_value       = i_bit_field_value;
        o_bit_field_valid      = bf_valid;
        o_bit_field_read_mask  = '0;
        o_bit_field_write_mask = '0;
        o_bit_field_write_data = bus_data_rep;
        if (bf_valid && !write) begin
            for (int w = 0; w < WORDS; w++) begin
                if (match[w] && !(ATOMIC_RD && (w > 0) && shadow_valid_q)) begin
                    o_bit_field_read_mask[w*BUS_WIDTH+:BUS_WIDTH] = '1;
                end
            end
        end
        if (bf_valid && write) begin
            if (commit) begin
                // Staged bytes only ever live below the last word, so OR is a merge.
                o_bit_field_write_mask = stage_mask_bits | strobe_bits;
                o_bit_field_write_data = stage_data_q;
                o_bit_field_write_data[(WORDS-1)*BUS_WIDTH+:BUS_WIDTH] = i_register_write_data;
            end else begin
                o_bit_field_write_mask = strobe_bits;
            end
        end
    end

    always_comb begin
        shadow_d       = shadow_q;
        shadow_valid_d = shadow_valid_q;
        stage_data_d   = stage_data_q;
        stage_mask_d   = stage_mask_q;
        if (ready && staged) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (access_strobe[b]) begin
                    stage_data_d[b*8+:8] = bus_data_rep[b*8+:8];
                end
            end
            stage_mask_d = stage_mask_q | access_strobe;
        end
        if (ready && commit) begin
            stage_mask_d = '0;
        end
        if (ready && word0_read) begin
            shadow_d       = i_bit_field_read_data;
            shadow_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q        <= '0;
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
            stage_data_q   <= '0;
            stage_mask_q   <= '0;
        end else begin
            count_q        <= count_d;
            shadow_q       <= shadow_d;
            shadow_valid_q <= shadow_valid_d;
            stage_data_q   <= stage_data_d;
            stage_mask_q   <= stage_mask_d;
        end
    end
endmodule

// File: tb/tb_rggen_register_atomic.sv
// Bench for rggen_register_atomic: a 64-bit register on a 32-bit bus at 0x10,
// plus a latency-3 instance and a write-only instance.
module tb_rggen_register_atomic;
    localparam int AW = 8;
    localparam int BW = 32;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]    access;
    logic [AW-1:0] address;
    logic [BW-1:0] wdata;
    logic [3:0]    strobe;
    logic          add_match;
    logic [DW-1:0] bf_value;
    logic [DW-1:0] bf_read_data;
    logic          valid0, valid3, validr;
    assign bf_read_data = bf_value;

    logic          a0, r0, bv0;
    logic [1:0]    st0;
    logic [BW-1:0] rd0;
    logic [DW-1:0] v0, rm0, wm0, wd0;
    logic          a3, r3, bv3;
    logic [1:0]    st3;
    logic [BW-1:0] rd3;
    logic [DW-1:0] v3, rm3, wm3, wd3;
    logic          ar, rr, bvr;
    logic [1:0]    str;
    logic [BW-1:0] rdr;
    logic [DW-1:0] vr, rmr, wmr, wdr;

    rggen_register_atomic #(.ADDRESS_WIDTH(AW), .OFFSET_ADDRESS('h10), .BUS_WIDTH(BW),
        .DATA_WIDTH(DW), .READY_LATENCY(0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_register_valid(valid0), .i_register_access(access),
        .i_register_address(address), .i_register_write_data(wdata), .i_register_strobe(strobe),
        .o_register_active(a0), .o_register_ready(r0), .o_register_status(st0),
        .o_register_read_data(rd0), .o_register_value(v0), .i_additional_match(add_match),
        .o_bit_field_valid(bv0), .o_bit_field_read_mask(rm0), .o_bit_field_write_mask(wm0),
        .o_bit_field_write_data(wd0), .i_bit_field_read_data(bf_read_data), .i_bit_field_value(bf_value));

    rggen_register_atomic #(.ADDRESS_WIDTH(AW), .OFFSET_ADDRESS('h10), .BUS_WIDTH(BW),
        .DATA_WIDTH(DW), .READY_LATENCY(3)) dut3 (
        .i_clk(clk), .i_rst(rst), .i_register_valid(valid3), .i_register_access(access),
        .i_register_address(address), .i_register_write_data(wdata), .i_register_strobe(strobe),
        .o_register_active(a3), .o_register_ready(r3), .o_register_status(st3),
        .o_register_read_data(rd3), .o_register_value(v3), .i_additional_match(add_match),
        .o_bit_field_valid(bv3), .o_bit_field_read_mask(rm3), .o_bit_field_write_mask(wm3),
        .o_bit_field_write_data(wd3), .i_bit_field_read_data(bf_read_data), .i_bit_field_value(bf_value));

    rggen_register_atomic #(.READABLE(1'b0), .ADDRESS_WIDTH(AW), .OFFSET_ADDRESS('h10),
        .BUS_WIDTH(BW), .DATA_WIDTH(DW), .READY_LATENCY(0)) dutr (
        .i_clk(clk), .i_rst(rst), .i_register_valid(validr), .i_register_access(access),
        .i_register_address(address), .i_register_write_data(wdata), .i_register_strobe(strobe),
        .o_register_active(ar), .o_register_ready(rr), .o_register_status(str),
        .o_register_read_data(rdr), .o_register_value(vr), .i_additional_match(add_match),
        .o_bit_field_valid(bvr), .o_bit_field_read_mask(rmr), .o_bit_field_write_mask(wmr),
        .o_bit_field_write_data(wdr), .i_bit_field_read_data(bf_read_data), .i_bit_field_value(bf_value));

    int checks   = 0;
    int failures = 0;

    // Reference model of the main register, kept per byte.
    logic [DW-1:0] m_shadow;
    bit            m_sv;
    logic [7:0]    m_stage_data [8];
    bit            m_stage_mask [8];
    logic [BW-1:0] exp_q [$];

    task automatic model_reset();
        m_shadow = '0;
        m_sv     = 1'b0;
        for (int b = 0; b < 8; b++) begin
            m_stage_data[b] = 8'h00;
            m_stage_mask[b] = 1'b0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One latency-0 access on the main register, checked against the model.
    task automatic main_access(input logic [AW-1:0] addr, input bit wr,
                               input logic [BW-1:0] d, input logic [3:0] s);
        bit            hit, e_bfv;
        int            word;
        logic [BW-1:0] e_rdata, got_exp;
        logic [DW-1:0] e_rmask, e_wmask, e_wdata;
        @(negedge clk);
        address = addr;
        access  = wr ? 2'b11 : 2'b10;
        wdata   = d;
        strobe  = s;
        valid0  = 1'b1;
        hit     = add_match && (addr >= 8'h10) && (addr <= 8'h17);
        word    = hit ? int'(addr - 8'h10) / 4 : 0;
        e_bfv   = hit && !(wr && word == 0);
        e_rdata = '0;
        e_rmask = '0;
        e_wmask = '0;
        e_wdata = '0;
        if (hit && !wr) begin
            if (word == 0) begin
                e_rdata = bf_value[31:0];
                e_rmask = 64'h00000000_FFFFFFFF;
            end else if (m_sv) begin
                e_rdata = m_shadow[63:32];
            end else begin
                e_rdata = bf_value[63:32];
                e_rmask = 64'hFFFFFFFF_00000000;
            end
            exp_q.push_back(e_rdata);
        end
        if (hit && wr && word == 1) begin
            for (int b = 0; b < 8; b++) begin
                if (b < 4) begin
                    e_wmask[b*8+:8] = m_stage_mask[b] ? 8'hFF : 8'h00;
                    e_wdata[b*8+:8] = m_stage_data[b];
                end else begin
                    e_wmask[b*8+:8] = s[b-4] ? 8'hFF : 8'h00;
                    e_wdata[b*8+:8] = d[(b-4)*8+:8];
                end
            end
        end
        #1;
        checks++;
        if (a0 !== hit) begin failures++; $display("FAIL active addr=%0h: got %0b expected %0b", addr, a0, hit); end
        checks++;
        if (r0 !== hit) begin failures++; $display("FAIL ready addr=%0h: got %0b expected %0b", addr, r0, hit); end
        checks++;
        if (bv0 !== e_bfv) begin failures++; $display("FAIL bit_field_valid addr=%0h wr=%0b: got %0b expected %0b", addr, wr, bv0, e_bfv); end
        checks++;
        if (st0 !== 2'b00) begin failures++; $display("FAIL status: got %0h expected 0", st0); end
        checks++;
        if (v0 !== bf_value) begin failures++; $display("FAIL register_value: got %0h expected %0h", v0, bf_value); end
        if (hit && !wr) begin
            got_exp = exp_q.pop_front();
            checks++;
            if (rd0 !== got_exp) begin failures++; $display("FAIL read_data addr=%0h: got %0h expected %0h", addr, rd0, got_exp); end
        end
        if (e_bfv) begin
            checks++;
            if (rm0 !== e_rmask) begin failures++; $display("FAIL read_mask addr=%0h: got %0h expected %0h", addr, rm0, e_rmask); end
            checks++;
            if (wm0 !== e_wmask) begin failures++; $display("FAIL write_mask addr=%0h: got %0h expected %0h", addr, wm0, e_wmask); end
            if (wr) begin
                checks++;
                if (wd0 !== e_wdata) begin failures++; $display("FAIL write_data addr=%0h: got %0h expected %0h", addr, wd0, e_wdata); end
            end
        end
        @(posedge clk);
        if (hit && !wr && word == 0) begin
            m_shadow = bf_value;
            m_sv     = 1'b1;
        end
        if (hit && wr && word == 0) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    m_stage_data[b] = d[b*8+:8];
                    m_stage_mask[b] = 1'b1;
                end
            end
        end
        if (hit && wr && word == 1) begin
            for (int b = 0; b < 8; b++) m_stage_mask[b] = 1'b0;
        end
        #1;
        valid0 = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (r0 !== 1'b0 || bv0 !== 1'b0) begin failures++; $display("FAIL reset ready/valid: got %0b/%0b expected 0/0", r0, bv0); end
        checks++;
        if (rm0 !== '0 || wm0 !== '0) begin failures++; $display("FAIL reset masks: got %0h/%0h expected 0/0", rm0, wm0); end
        checks++;
        if (st0 !== 2'b00) begin failures++; $display("FAIL reset status: got %0h expected 0", st0); end
    endtask

    task automatic test_spec_sequence();
        add_match = 1'b1;
        bf_value  = 64'h11112222_33334444;
        main_access(8'h10, 1'b0, 32'h0, 4'h0);
        bf_value  = 64'hAAAABBBB_CCCCDDDD;
        main_access(8'h14, 1'b0, 32'h0, 4'h0);
        main_access(8'h10, 1'b1, 32'h12345678, 4'hF);
        main_access(8'h14, 1'b1, 32'hDEADBEEF, 4'hF);
    endtask

    task automatic test_reset_mid_stage();
        add_match = 1'b1;
        main_access(8'h10, 1'b1, 32'h12345678, 4'h3);
        apply_reset();
        main_access(8'h14, 1'b1, 32'h00000000, 4'hF);
    endtask

    task automatic test_repeat_and_empty();
        add_match = 1'b1;
        main_access(8'h10, 1'b1, 32'h000000AA, 4'h1);
        main_access(8'h10, 1'b1, 32'h000000BB, 4'h1);
        main_access(8'h14, 1'b1, 32'h55667788, 4'h0);
        main_access(8'h14, 1'b1, 32'h99AABBCC, 4'hC);
    endtask

    task automatic test_miss();
        add_match = 1'b1;
        main_access(8'h18, 1'b0, 32'h0, 4'h0);
        main_access(8'h0C, 1'b1, 32'h1, 4'hF);
        add_match = 1'b0;
        main_access(8'h10, 1'b0, 32'h0, 4'h0);
        main_access(8'h14, 1'b1, 32'h1, 4'hF);
        add_match = 1'b1;
    endtask

    task automatic test_random();
        logic [AW-1:0] addrs [6];
        addrs[0] = 8'h10; addrs[1] = 8'h14; addrs[2] = 8'h10;
        addrs[3] = 8'h14; addrs[4] = 8'h18; addrs[5] = 8'h0C;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 3) == 0) bf_value = {$urandom, $urandom};
            add_match = ($urandom_range(0, 7) != 0);
            main_access(addrs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                        $urandom, 4'($urandom_range(0, 15)));
        end
        add_match = 1'b1;
    endtask

    // Latency-3 instance: word-0 read abandoned after two cycles.
    task automatic test_drop();
        @(negedge clk);
        address = 8'h10; access = 2'b10; add_match = 1'b1; valid3 = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (r3 !== 1'b0 || bv3 !== 1'b0) begin failures++; $display("FAIL drop_wait cyc=%0d: got %0b/%0b expected 0/0", c, r3, bv3); end
            @(negedge clk);
        end
        valid3 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (r3 !== 1'b0 || bv3 !== 1'b0) begin failures++; $display("FAIL drop_idle cyc=%0d: got %0b/%0b expected 0/0", c, r3, bv3); end
            @(negedge clk);
        end
        // No snapshot was taken, so word 1 must still read live.
        bf_value = {$urandom, $urandom};
        address = 8'h14; valid3 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            if (c == 4) begin
                checks++;
                if (r3 !== 1'b1 || rd3 !== bf_value[63:32] || rm3 !== 64'hFFFFFFFF_00000000) begin
                    failures++;
                    $display("FAIL drop_no_shadow: got ready=%0b data=%0h mask=%0h expected 1/%0h/ffffffff00000000", r3, rd3, rm3, bf_value[63:32]);
                end
            end
            @(negedge clk);
        end
        valid3 = 1'b0;
    endtask

    task automatic test_latency();
        @(negedge clk);
        address = 8'h10; access = 2'b10; add_match = 1'b1; valid3 = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1;
            checks++;
            if (r3 !== (c == 4) || bv3 !== (c == 4)) begin
                failures++;
                $display("FAIL latency cyc=%0d: got ready=%0b bfv=%0b expected %0b", c, r3, bv3, (c == 4));
            end
            if (c == 4) begin
                checks++;
                if (rd3 !== bf_value[31:0]) begin failures++; $display("FAIL latency_data: got %0h expected %0h", rd3, bf_value[31:0]); end
            end
            @(negedge clk);
        end
        valid3 = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        address = 8'h10; access = 2'b10; valid3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (r3 !== 1'b0 || bv3 !== 1'b0) begin failures++; $display("FAIL reset_wait cyc=%0d: got %0b/%0b expected 0/0", c, r3, bv3); end
            @(negedge clk);
        end
        valid3 = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic test_readable();
        @(negedge clk);
        address = 8'h10; access = 2'b10; add_match = 1'b1; validr = 1'b1;
        #1;
        checks++;
        if (ar !== 1'b0 || rr !== 1'b0) begin failures++; $display("FAIL readable0_read: got active=%0b ready=%0b expected 0/0", ar, rr); end
        @(negedge clk);
        access = 2'b11; strobe = 4'hF;
        #1;
        checks++;
        if (ar !== 1'b1 || rr !== 1'b1) begin failures++; $display("FAIL readable0_write: got active=%0b ready=%0b expected 1/1", ar, rr); end
        @(negedge clk);
        validr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; valid0 = 1'b0; valid3 = 1'b0; validr = 1'b0;
        access = 2'b10; address = '0; wdata = '0; strobe = '0; add_match = 1'b1;
        bf_value = '0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_drop();
        test_latency();
        test_spec_sequence();
        test_reset_mid_stage();
        test_repeat_and_empty();
        test_miss();
        test_readable();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
